// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the AES access arbiter: FSM state encoding,
// datapath widths and default configuration values.
package aes_arb_pkg;

  localparam int unsigned AES_W   = 128;
  localparam int unsigned TOKEN_W = 2;

  localparam int unsigned           DEF_NUM_AGENTS       = 4;
  localparam logic [2**TOKEN_W-1:0] DEF_VALID_TOKEN_MASK = 4'b1110;
  localparam int unsigned           DEF_TIMEOUT_CYCLES   = 64;
  localparam int unsigned           DEF_LOCKOUT_THRESH   = 3;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StResp
  } arb_state_e;

endpackage

// File: rtl/aes_access_arbiter_if.sv
// Agent-side and core-side signal bundle of the AES access arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface aes_access_arbiter_if
  import aes_arb_pkg::*;
#(
  parameter int unsigned NUM_AGENTS = DEF_NUM_AGENTS
);

  logic [NUM_AGENTS-1:0]         req;
  logic [TOKEN_W*NUM_AGENTS-1:0] token;
  logic [AES_W*NUM_AGENTS-1:0]   plaintext;
  logic [AES_W*NUM_AGENTS-1:0]   key;
  logic [NUM_AGENTS-1:0]         grant;
  logic [NUM_AGENTS-1:0]         resp_valid;
  logic                          resp_err;
  logic [AES_W-1:0]              resp_data;
  logic [NUM_AGENTS-1:0]         locked;
  logic                          core_start;
  logic [AES_W-1:0]              core_plaintext;
  logic [AES_W-1:0]              core_key;
  logic                          core_busy;
  logic                          core_done;
  logic [AES_W-1:0]              core_ciphertext;

  modport slave (
    input  req, token, plaintext, key, core_busy, core_done, core_ciphertext,
    output grant, resp_valid, resp_err, resp_data, locked, core_start, core_plaintext, core_key
  );

  modport master (
    output req, token, plaintext, key, core_busy, core_done, core_ciphertext,
    input  grant, resp_valid, resp_err, resp_data, locked, core_start, core_plaintext, core_key
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: the request at index i_ptr has the
// highest priority, then i_ptr+1 and so on with wrap-around; one-hot winner out.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned PtrW = 2
) (
  input  logic [N-1:0]    i_req,
  input  logic [PtrW-1:0] i_ptr,
  output logic [N-1:0]    o_gnt
);

  logic [PtrW-1:0] w_idx;
  logic            w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = PtrW'((32'(i_ptr) + i) % N);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_access_arbiter.sv
// Round-robin arbiter sharing one AES core between token-authenticated agents.
// Define AES_ARB_LOCKOUT_EN to lock out agents after repeated invalid tokens.
module aes_access_arbiter
  import aes_arb_pkg::*;
#(
  parameter int unsigned           NUM_AGENTS       = DEF_NUM_AGENTS,
  parameter logic [2**TOKEN_W-1:0] VALID_TOKEN_MASK = DEF_VALID_TOKEN_MASK,
  parameter int unsigned           TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
  parameter int unsigned           LOCKOUT_THRESH   = DEF_LOCKOUT_THRESH
) (
  input logic                 clk,
  input logic                 rst_n,
  aes_access_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e            r_state, w_state_d;
  logic [IdxW-1:0]       r_idx, r_ptr, w_sel_idx;
  logic [TOKEN_W-1:0]    r_token, w_sel_token;
  logic [AES_W-1:0]      r_plaintext, r_key, r_data;
  logic [TmoW-1:0]       r_tmo;
  logic                  r_tmo_err;
  logic [NUM_AGENTS-1:0] w_locked, w_eligible, w_gnt, w_idx_oh;
  logic                  w_select, w_tok_ok, w_launch, w_tmo_hit;

  assign w_eligible = bus.req & ~w_locked;

  rr_arbiter #(
    .N    (NUM_AGENTS),
    .PtrW (IdxW)
  ) u_rr_arbiter (
    .i_req (w_eligible),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_sel_idx = '0;
    for (int unsigned i = 0; i < NUM_AGENTS; i++) begin
      if (w_gnt[i]) w_sel_idx = IdxW'(i);
    end
  end

  assign w_sel_token = bus.token[w_sel_idx*TOKEN_W +: TOKEN_W];
  assign w_tok_ok    = VALID_TOKEN_MASK[w_sel_token];
  assign w_select    = (r_state == StIdle) && (|w_eligible);
  assign w_launch    = (r_state == StLaunch) && !bus.core_busy;
  assign w_tmo_hit   = (r_tmo == TmoW'(TIMEOUT_CYCLES - 1));
  assign w_idx_oh    = NUM_AGENTS'(1) << r_idx;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_select) w_state_d = w_tok_ok ? StLaunch : StResp;
      StLaunch: if (w_launch) w_state_d = StWait;
      StWait:   if (bus.core_done || w_tmo_hit) w_state_d = StResp;
      StResp:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_ptr       <= '0;
      r_token     <= '0;
      r_plaintext <= '0;
      r_key       <= '0;
      r_data      <= '0;
      r_tmo       <= '0;
      r_tmo_err   <= 1'b0;
    end else begin
      if (w_select) begin
        r_idx       <= w_sel_idx;
        r_token     <= w_sel_token;
        r_plaintext <= bus.plaintext[w_sel_idx*AES_W +: AES_W];
        r_key       <= bus.key[w_sel_idx*AES_W +: AES_W];
        r_ptr       <= (w_sel_idx == IdxW'(NUM_AGENTS - 1)) ? '0 : w_sel_idx + 1'b1;
        r_tmo_err   <= 1'b0;
      end
      if (w_launch) r_tmo <= '0;
      // core_done wins over a timeout landing in the same cycle
      if (r_state == StWait) begin
        if (bus.core_done) begin
          r_data <= bus.core_ciphertext;
        end else if (w_tmo_hit) begin
          r_data    <= '0;
          r_tmo_err <= 1'b1;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end
    end
  end

`ifdef AES_ARB_LOCKOUT_EN
  localparam int unsigned FailW = $clog2(LOCKOUT_THRESH + 1);

  logic [FailW-1:0]      r_fail [NUM_AGENTS];
  logic [NUM_AGENTS-1:0] r_locked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked <= '0;
      for (int unsigned i = 0; i < NUM_AGENTS; i++) r_fail[i] <= '0;
    end else if (w_select) begin
      if (w_tok_ok) begin
        r_fail[w_sel_idx] <= '0;
      end else if (r_fail[w_sel_idx] != FailW'(LOCKOUT_THRESH)) begin
        r_fail[w_sel_idx] <= r_fail[w_sel_idx] + 1'b1;
        if (r_fail[w_sel_idx] == FailW'(LOCKOUT_THRESH - 1)) r_locked[w_sel_idx] <= 1'b1;
      end
    end
  end

  assign w_locked = r_locked;
`else
  assign w_locked = '0;
`endif

  // Error covers both a rejected token and a core timeout
  assign bus.grant          = (r_state != StIdle) ? w_idx_oh : '0;
  assign bus.resp_valid     = (r_state == StResp) ? w_idx_oh : '0;
  assign bus.resp_err       = (r_state == StResp) && (r_tmo_err || !VALID_TOKEN_MASK[r_token]);
  assign bus.resp_data      = r_data;
  assign bus.locked         = w_locked;
  assign bus.core_start     = w_launch;
  assign bus.core_plaintext = r_plaintext;
  assign bus.core_key       = r_key;

endmodule

// File: doc/aes_access_arbiter.md
AES_ACCESS_ARBITER -- requirements
Module: aes_access_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_AGENTS, default 4, giving the number of requesting agents.
REQ-002 The block SHALL have parameter VALID_TOKEN_MASK, default 4'b1110: token value t is valid iff bit t is 1, so 2'b00 is invalid.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 64: the maximum number of WAIT cycles before the operation is aborted.
REQ-004 The block SHALL have parameter LOCKOUT_THRESH, default 3: the number of consecutive invalid requests that locks out an agent.
REQ-005 The block SHALL have these ports:
- clk  in  1  the single clock.
- rst_n  in  1  reset; asynchronous and active-low.
- req  in  NUM_AGENTS  per-agent request, held high until that agent's resp_valid.
- token  in  2*NUM_AGENTS  per-agent 2-bit agent token.
- plaintext  in  128*NUM_AGENTS  per-agent plaintext.
- key  in  128*NUM_AGENTS  per-agent key.
- grant  out  NUM_AGENTS  one-hot owner of the AES core.
- resp_valid  out  NUM_AGENTS  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: bad token or timeout.
- resp_data  out  128  ciphertext.
- locked  out  NUM_AGENTS  per-agent lockout status.
- core_start  out  1  one-cycle start pulse to the AES core.
- core_plaintext  out  128  plaintext to the core.
- core_key  out  128  key to the core.
- core_busy  in  1  core busy.
- core_done  in  1  core done pulse.
- core_ciphertext  in  128  core result.

Function
REQ-006 The FSM SHALL have states IDLE, LAUNCH, WAIT and RESP.
REQ-007 In IDLE with any eligible req (req high and not locked), the block SHALL select one agent by round-robin, starting at the agent after the last selected one.
REQ-008 On selection the block SHALL register the agent index, token, plaintext and key.
- Valid token: the FSM SHALL go to LAUNCH.
- Invalid token: the FSM SHALL go to RESP with the error flag set.
- The round-robin pointer SHALL update in either case.
REQ-009 grant[idx] SHALL be high in LAUNCH, WAIT and RESP, and zero in IDLE.
REQ-010 In LAUNCH with core_busy=0, the block SHALL:
- pulse core_start for exactly one cycle;
- drive the registered plaintext and key on core_plaintext/core_key;
- go to WAIT.
With core_busy=1 it SHALL hold in LAUNCH without pulsing core_start.
REQ-011 In WAIT, on core_done=1 the block SHALL capture core_ciphertext into resp_data and go to RESP.
REQ-012 In WAIT, the timeout counter SHALL count cycles; on reaching TIMEOUT_CYCLES without core_done the block SHALL go to RESP with the error flag set and resp_data=0.
REQ-013 In RESP, the block SHALL:
- pulse resp_valid[idx] for exactly one cycle;
- hold resp_err valid during that cycle;
- return to IDLE.
REQ-014 Latency (valid token):
- req sampled at edge k -> core_start in cycle k+1;
- core_done at cycle d -> resp_valid in cycle d+1;
- IDLE again at d+2.
REQ-015 Latency (invalid token): resp_valid and resp_err SHALL be high in cycle k+1, with no core_start.
REQ-016 The block SHALL ignore req deassertion after selection: the operation completes and resp_valid still pulses.
REQ-017 core_done outside WAIT SHALL be ignored.
REQ-018 resp_data SHALL hold its value until the next RESP.
REQ-019 With all agents requesting continuously, the block SHALL grant agents 0,1,2,3,0,... with no agent starved.

Reset
REQ-020 On rst_n=0 the block SHALL immediately:
- set the state to IDLE;
- set grant, resp_valid, resp_err, resp_data, core_start, core_plaintext, core_key and locked to 0;
- clear the timeout counter, fail counters and index registers;
- set the round-robin pointer so agent 0 has first priority.
REQ-021 A reset mid-operation SHALL abort it: no resp_valid is issued, and any late core_done after reset release SHALL be ignored in IDLE.

Configuration
REQ-022 When AES_ARB_LOCKOUT_EN is defined, the block SHALL keep a per-agent saturating fail counter that:
- increments on each invalid-token selection;
- clears on each valid-token selection;
- at LOCKOUT_THRESH sets locked[i], after which agent i is excluded from arbitration until reset.
REQ-023 Without AES_ARB_LOCKOUT_EN, locked SHALL be constant 0, no fail counters SHALL exist, and invalid requests SHALL always receive an error response.

Structure
REQ-024 Package aes_arb_pkg SHALL hold:
- the FSM state enum;
- AES_W=128;
- TOKEN_W=2;
- the default parameter constants.
REQ-025 Round-robin selection SHALL be sub-module rr_arbiter: combinational rotating-priority picker, inputs request vector and pointer, output one-hot winner.

Verification
REQ-026 Agent 0 token 2'b00 requests -> resp_valid[0] and resp_err=1 next cycle, core_start never asserted.
REQ-027 Agent 1 token 2'b01, plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, with a core model -> core_start one cycle after req, resp_data=69c4e0d86a7b0430d8cdb78070b4c55a, resp_err=0.
REQ-028 All four agents request with valid tokens continuously -> grant order 0,1,2,3,0 and exactly one resp_valid per operation.
REQ-029 Core model never asserts core_done -> resp_err=1 and resp_data=0 after 64 WAIT cycles, then the FSM is back in IDLE.
REQ-030 rst_n pulsed low during WAIT -> all outputs 0 immediately, and a core_done arriving 3 cycles after reset release produces no resp_valid.
REQ-031 With AES_ARB_LOCKOUT_EN defined, agent 2 makes 3 invalid requests -> locked[2]=1 and a subsequent valid request from agent 2 is never granted; without the macro the same sequence -> locked=0 and every request is answered.
